// File: rtl/tb_ctrl_pkg.sv
// tb_ctrl_pkg: command type shared by the input conditioner and the tail-light sequencer pair.
package tb_ctrl_pkg;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int TICK_DIV_DEF = 8;
  typedef struct packed {
    logic left;
    logic right;
    logic brake;
    logic fog;
    logic alarm;
  } tb_cmd_t;
  // Both stalks high is treated as a conflict and blanks both turn commands.
  function automatic tb_cmd_t make_cmd(input logic l, input logic r, input logic b, input logic f, input logic a);
    return tb_cmd_t'{left: l & ~r, right: r & ~l, brake: b, fog: f, alarm: a};
  endfunction
endpackage

// File: rtl/debounce_sync.sv
// debounce_sync: 2-flop synchroniser followed by a DEB_CYCLES-sample debouncer.
module debounce_sync import tb_ctrl_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic s1_q, s2_q, db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    db_d = (s2_q != db_q && cnt_q == LAST) ? s2_q : db_q;
    cnt_d = (s2_q == db_q || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      db_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      db_q <= db_d;
      cnt_q <= cnt_d;
    end
  end
  assign db = db_q;
endmodule

// File: rtl/tb_input_conditioner.sv
// tb_input_conditioner: debounces driver controls and presents tick-aligned commands to the sequencers.
module tb_input_conditioner import tb_ctrl_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_left,
  input  logic sw_right,
  input  logic sw_brake,
  input  logic sw_fog,
  input  logic btn_hazard,
  output logic tick,
  output logic left,
  output logic right,
  output logic brake,
  output logic fog,
  output logic alarm
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  logic [4:0] raw, db;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic haz_prev_q, alarm_latch_q, alarm_latch_d;
  tb_cmd_t cmd_q, cmd_d;
  assign raw = {sw_left, sw_right, sw_brake, sw_fog, btn_hazard};
  for (genvar i = 0; i < 5; i++) begin : g_db
    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_db (
      .clk(clk),
      .reset(reset),
      .raw(raw[i]),
      .db(db[i])
    );
  end
  assign tick = pcnt_q == PLAST;
  // The output samples the latch before this cycle's toggle, so a press in a tick cycle shows one tick later.
  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    alarm_latch_d = alarm_latch_q ^ (db[0] & ~haz_prev_q);
    cmd_d = tick ? make_cmd(db[4], db[3], db[2], db[1], alarm_latch_q) : cmd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      haz_prev_q <= 1'b0;
      alarm_latch_q <= 1'b0;
      cmd_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      haz_prev_q <= db[0];
      alarm_latch_q <= alarm_latch_d;
      cmd_q <= cmd_d;
    end
  end
  assign {left, right, brake, fog, alarm} = cmd_q;
endmodule
